// File: rtl/ram_pkg.sv
// ram_pkg: default geometry and byte-lane helpers shared by ram and ram_array.
package ram_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH = 2 ** ADDR_W_DEF;

    function automatic int laneCount(input int width);
        return (width + 7) / 8;
    endfunction

    localparam int LANES = laneCount(DATA_W_DEF);
endpackage

// File: rtl/ram_array.sv
// ram_array: word storage with clear-all, lane-masked writes and a write-first read word.
module ram_array
    import ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORDS = DEPTH,
    parameter int LANE_N = LANES
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [LANE_N-1:0] laneEn,
    output logic [DATA_W-1:0] rdData
);
    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] bitMask;
    logic [DATA_W-1:0] merged;

    for (genvar i = 0; i < DATA_W; i++) begin : g_mask
        assign bitMask[i] = laneEn[i/8];
    end

    // merged word is both what gets stored and what a write cycle reads back
    assign merged = (wrData & bitMask) | (mem[addr] & ~bitMask);
    assign rdData = wrEn ? merged : mem[addr];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (wrEn) begin
            mem[addr] <= merged;
        end
    end
endmodule

// File: rtl/ram.sv
// ram: single-port write-first RAM with registered read and full clear on sync active-low reset.
// Defining RAM_BYTE_WE_EN adds the wrByteEn port for per-byte write lanes.
module ram
    import ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              wrEnable,
`ifdef RAM_BYTE_WE_EN
    input  logic [DATA_W/8-1:0] wrByteEn,
`endif
    output logic [DATA_W-1:0] dataOut
);
    localparam int LANE_N = laneCount(DATA_W);

    logic [LANE_N-1:0] laneEn;
    logic [DATA_W-1:0] rdData;

`ifdef RAM_BYTE_WE_EN
    assign laneEn = wrByteEn;
`else
    assign laneEn = '1;
`endif

    ram_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .WORDS (2 ** ADDR_W),
        .LANE_N(LANE_N)
    ) u_array (
        .clk   (clk),
        .clear (!rst_n),
        .wrEn  (wrEnable && rst_n),
        .addr  (addr),
        .wrData(dataIn),
        .laneEn(laneEn),
        .rdData(rdData)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) dataOut <= '0;
        else dataOut <= rdData;
    end
endmodule

// File: tb/tb_ram.sv
// tb_ram: directed checks of ram reset, write-first reads, addressing and byte lanes.
module tb_ram;
    logic        clk;
    logic        rst_n;
    logic [7:0]  addr;
    logic [31:0] dataIn;
    logic        wrEnable;
    logic [31:0] dataOut;
`ifdef RAM_BYTE_WE_EN
    logic [3:0]  wrByteEn;
`endif
    int errors = 0;
    int checks = 0;

    ram dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .dataIn  (dataIn),
        .wrEnable(wrEnable),
`ifdef RAM_BYTE_WE_EN
        .wrByteEn(wrByteEn),
`endif
        .dataOut (dataOut)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] exp);
        checks++;
        assert (dataOut === exp)
        else begin
            errors++;
            $error("FAIL %s: dataOut=%h expected=%h", tag, dataOut, exp);
        end
    endtask

    initial begin
        rst_n = 0; wrEnable = 1; addr = 8'h00; dataIn = 32'hFFFFFFFF;
`ifdef RAM_BYTE_WE_EN
        wrByteEn = 4'hF;
`endif
        step(); check("reset_out", 32'h0);
        rst_n = 1; wrEnable = 0; addr = 8'h01;
        step(); check("read01_after_reset", 32'h0);
        wrEnable = 1; addr = 8'h00; dataIn = 32'hC0FFEE00;
        step(); check("write00_first", 32'hC0FFEE00);
        wrEnable = 0;
        step(); check("read00", 32'hC0FFEE00);
        addr = 8'h01;
        step(); check("read01", 32'h0);
        addr = 8'h78;
        step(); check("read78", 32'h0);
        addr = 8'h00; #2;
        check("hold_between_edges", 32'h0);
        wrEnable = 1; addr = 8'hFF; dataIn = 32'h12345678;
        step(); check("writeFF_first", 32'h12345678);
        wrEnable = 0;
        step(); check("readFF", 32'h12345678);
        addr = 8'h00;
        step(); check("read00_no_alias", 32'hC0FFEE00);
        wrEnable = 1; addr = 8'h20; dataIn = 32'hAAAA0001;
        step(); check("b2b_first", 32'hAAAA0001);
        dataIn = 32'hBBBB0002;
        step(); check("b2b_second", 32'hBBBB0002);
        wrEnable = 0; dataIn = 32'h00000099;
        step(); check("read20_last", 32'hBBBB0002);
        step(); check("no_write_when_low", 32'hBBBB0002);
        wrEnable = 1; addr = 8'h10; dataIn = 32'hDEADBEEF;
        step(); check("write10", 32'hDEADBEEF);
        rst_n = 0; dataIn = 32'h11111111;
        step(); check("reset_over_write", 32'h0);
        rst_n = 1; wrEnable = 0;
        step(); check("read10_cleared", 32'h0);
        addr = 8'h00;
        step(); check("read00_cleared", 32'h0);
        addr = 8'hFF;
        step(); check("readFF_cleared", 32'h0);
        rst_n = 0; wrEnable = 1; addr = 8'h03; dataIn = 32'h77777777;
        step(); check("reset_again", 32'h0);
        rst_n = 1; dataIn = 32'h5A5A5A5A;
        step(); check("write_first_cycle", 32'h5A5A5A5A);
        wrEnable = 0;
        step(); check("read03", 32'h5A5A5A5A);
`ifdef RAM_BYTE_WE_EN
        wrEnable = 1; addr = 8'h05; dataIn = 32'hAABBCCDD; wrByteEn = 4'hF;
        step(); check("be_full", 32'hAABBCCDD);
        dataIn = 32'h11223344; wrByteEn = 4'h5;
        step(); check("be_merge_first", 32'hAA22CC44);
        wrEnable = 0;
        step(); check("be_merge_read", 32'hAA22CC44);
        wrEnable = 1; dataIn = 32'h99999999; wrByteEn = 4'h0;
        step(); check("be_none_first", 32'hAA22CC44);
        wrEnable = 0; wrByteEn = 4'hF;
        step(); check("be_none_read", 32'hAA22CC44);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the word width in bits.
REQ-002 Parameter ADDR_W, default 8, SHALL set the address width; DEPTH = 2**ADDR_W words (256).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the reset: synchronous, active-low.
REQ-005 Port addr, input, ADDR_W bits, SHALL give the word address for both the write and the read.
REQ-006 Port dataIn, input, DATA_W bits, SHALL carry the write data.
REQ-007 Port wrEnable, input, 1 bit, SHALL request a write of dataIn to addr when high.
REQ-008 Port dataOut, output, DATA_W bits, SHALL be the registered read data.
REQ-009 Port wrByteEn, input, DATA_W/8 bits, SHALL exist only under RAM_BYTE_WE_EN (see Configuration).

Function
REQ-010 Storage SHALL be DEPTH words of DATA_W bits, single port, one access per cycle.
REQ-011 With rst_n high and wrEnable high at a rising edge, mem[addr] SHALL take dataIn at that edge.
REQ-012 With wrEnable low, memory contents SHALL be unchanged.
REQ-013 On every rising edge with rst_n high, dataOut SHALL load the word at addr: read latency exactly 1 cycle.
REQ-014 On a write cycle, dataOut SHALL load the newly written value (write-first); the old contents are not returned.
REQ-015 dataOut SHALL hold its value between edges; it SHALL NOT change combinationally with addr.
REQ-016 Every address 0 to DEPTH-1 SHALL be valid, with no aliasing or wrap-around; address 0xFF SHALL be the last word.
REQ-017 Back-to-back writes to the same address SHALL leave the last written value in memory.

Reset
REQ-018 While rst_n is low at a rising edge, dataOut SHALL become 0 and every memory word SHALL become 0 in that same edge.
REQ-019 While rst_n is low, wrEnable and wrByteEn SHALL be ignored, and no write SHALL occur.
REQ-020 A reset asserted mid-operation SHALL take precedence over a write in the same cycle.
REQ-021 In the first cycle after rst_n goes high, the design SHALL operate normally, with no extra initialisation latency.

Configuration
REQ-022 Macro RAM_BYTE_WE_EN defined: port wrByteEn is present.
- A write SHALL update only byte lanes whose wrByteEn bit is 1; bit i controls bits [8i+7:8i].
- Lanes with a 0 bit SHALL keep their old value.
- Write-first read (REQ-014) SHALL return the merged word.
REQ-023 Macro RAM_BYTE_WE_EN undefined: port wrByteEn is absent, and every write SHALL update the full word.
REQ-024 With the macro defined, DATA_W SHALL be a multiple of 8.

Structure
REQ-025 Package ram_pkg SHALL hold:
- DATA_W and ADDR_W defaults
- DEPTH
- the derived byte-lane count
REQ-026 The storage array, write logic and per-lane merge SHALL be in sub-module ram_array.
REQ-027 The top-level ram SHALL hold the output register, the reset gating and the macro-controlled port.

Verification
REQ-028 Reset, then read addr 0x01 -> dataOut = 0x00000000 one cycle later.
REQ-029 Write 0xC0FFEE00 to addr 0x00, then read addr 0x00 with wrEnable=0 -> dataOut = 0xC0FFEE00 on the next edge.
REQ-030 After REQ-029, read addr 0x01 and then addr 0x78 -> dataOut = 0x00000000 for each, each one cycle after the address is applied.
REQ-031 Write 0x12345678 to addr 0xFF -> dataOut = 0x12345678 on the write edge (write-first); a read of 0xFF then returns 0x12345678.
REQ-032 Write 0xDEADBEEF to addr 0x10, assert rst_n low for one edge with wrEnable=1 and dataIn=0x11111111, then read 0x10 -> dataOut = 0 after reset and 0x00000000 on read.
REQ-033 With RAM_BYTE_WE_EN: write 0xAABBCCDD to 0x05 with wrByteEn=4'hF, then write 0x11223344 to 0x05 with wrByteEn=4'h5 -> read of 0x05 returns 0xAA22CC44.
